decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 190 +++++++++++++++++++
 tb/tb_decode_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Instruction queue between fetch and decode: a circular buffer that pre-decodes
// control/memory/reserved flags and delay-slot membership at push time.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic             out_is_bj,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_ri,
    output logic             out_in_ds,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_bj;
        logic        mem_read;
        logic        mem_write;
        logic        ri;
        logic        in_ds;
    } entry_t;

    function automatic logic f_is_bj(input logic [31:0] instr);
        logic r;
        case (instr[31:26]) inside
            [6'h01:6'h07]: r = 1'b1;
            6'h00:         r = (instr[5:0] == 6'h08) || (instr[5:0] == 6'h09);
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic f_mem_read(input logic [31:0] instr);
        logic r;
        case (instr[31:26])
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic f_mem_write(input logic [31:0] instr);
        logic r;
        case (instr[31:26])
            6'h28, 6'h29, 6'h2B: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic f_ri(input logic [31:0] instr);
        logic r;
        case (instr[31:26]) inside
            [6'h00:6'h10], 6'h1C, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B: r = 1'b0;
            default:             r = 1'b1;
        endcase
        return r;
    endfunction

    entry_t           mem_r [DEPTH];
    entry_t           head_r;
    entry_t           head_next_s;
    entry_t           new_entry_s;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             ds_pending_r;
    logic             ds_pending_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             push_s;
    logic             pop_s;

    assign push_s = in_valid & in_ready_r & ~flush;
    assign pop_s  = out_valid_r & out_ready & ~flush;

    // Pre-decode the incoming word; delay-slot status comes from the previous push.
    always_comb begin
        new_entry_s.instr     = in_instr;
        new_entry_s.pc        = in_pc;
        new_entry_s.is_bj     = f_is_bj(in_instr);
        new_entry_s.mem_read  = f_mem_read(in_instr);
        new_entry_s.mem_write = f_mem_write(in_instr);
        new_entry_s.ri        = f_ri(in_instr);
        new_entry_s.in_ds     = ds_pending_r;
    end

    // Next pointers, occupancy, delay-slot tracker and next head entry.
    always_comb begin
        wr_ptr_next_s     = wr_ptr_r;
        rd_ptr_next_s     = rd_ptr_r;
        count_next_s      = count_r;
        ds_pending_next_s = ds_pending_r;
        head_next_s       = '0;
        if (flush) begin
            wr_ptr_next_s     = '0;
            rd_ptr_next_s     = '0;
            count_next_s      = '0;
            ds_pending_next_s = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_next_s     = wr_ptr_r + PTR_ONE;
                ds_pending_next_s = new_entry_s.is_bj;
            end else begin
                wr_ptr_next_s     = wr_ptr_r;
                ds_pending_next_s = ds_pending_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CNT_ONE;
                2'b01:   count_next_s = count_r - CNT_ONE;
                default: count_next_s = count_r;
            endcase
        end
        // The word being written this cycle becomes the head only when it lands on the new read slot.
        if (count_next_s == '0) begin
            head_next_s = '0;
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = new_entry_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Control state and registered head/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            ds_pending_r <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            head_r       <= '0;
        end else begin
            wr_ptr_r     <= wr_ptr_next_s;
            rd_ptr_r     <= rd_ptr_next_s;
            count_r      <= count_next_s;
            ds_pending_r <= ds_pending_next_s;
            in_ready_r   <= (count_next_s != FULL_CNT);
            out_valid_r  <= (count_next_s != '0);
            head_r       <= head_next_s;
        end
    end

    // Entry storage; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= new_entry_s;
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign count         = count_r;
    assign out_instr     = head_r.instr;
    assign out_pc        = head_r.pc;
    assign out_is_bj     = head_r.is_bj;
    assign out_mem_read  = head_r.mem_read;
    assign out_mem_write = head_r.mem_write;
    assign out_ri        = head_r.ri;
    assign out_in_ds     = head_r.in_ds;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH=4).
module tb_decode_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_is_bj;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_ri;
    logic        out_in_ds;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    decode_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_is_bj(out_is_bj),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_ri(out_ri), .out_in_ds(out_in_ds), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int y;
        logic acc;
        logic [31:0] exp_head;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_instr = 32'h8C220004;
        in_pc = 32'h00000040; out_ready = 1'b0;
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_instr", out_instr, 32'd0);

        // lw after reset
        rst = 1'b0; in_valid = 1'b1; in_instr = 32'h8C220004; in_pc = 32'hBFC00000;
        tick();
        in_valid = 1'b0;
        chk("lw_valid", 32'(out_valid), 32'd1);
        chk("lw_mem_read", 32'(out_mem_read), 32'd1);
        chk("lw_pc", out_pc, 32'hBFC00000);
        chk("lw_instr", out_instr, 32'h8C220004);
        chk("lw_count", 32'(count), 32'd1);
        chk("lw_is_bj", 32'(out_is_bj), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_empty_valid", 32'(out_valid), 32'd0);
        chk("pop_empty_pc", out_pc, 32'd0);

        // beq then addu: delay-slot flag
        in_valid = 1'b1; in_instr = 32'h10000003; in_pc = 32'h00000100;
        tick();
        in_instr = 32'h00221821; in_pc = 32'h00000104;
        tick();
        in_valid = 1'b0;
        chk("beq_count", 32'(count), 32'd2);
        chk("beq_is_bj", 32'(out_is_bj), 32'd1);
        chk("beq_in_ds", 32'(out_in_ds), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("addu_instr", out_instr, 32'h00221821);
        chk("addu_is_bj", 32'(out_is_bj), 32'd0);
        chk("addu_in_ds", 32'(out_in_ds), 32'd1);
        chk("addu_ri", 32'(out_ri), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("drain2_valid", 32'(out_valid), 32'd0);

        // fill past full, fifth word dropped
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = 32'h00000020 + 32'(i); in_pc = 32'h00000200 + 32'(4 * i);
            tick();
            chk("fill_count", 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
            chk("fill_in_ready", 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_instr", out_instr, 32'h00000020 + 32'(k));
            chk("drain_pc", out_pc, 32'h00000200 + 32'(4 * k));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // full queue with continuous push and pop
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = 32'h00001020 + 32'(i); in_pc = 32'h00000300 + 32'(4 * i);
            tick();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        y = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_instr = 32'h00002020 + 32'(y); in_pc = 32'h00000400 + 32'(4 * y);
            exp_head = (c < 4) ? 32'h00001020 + 32'(c) : 32'h00002020 + 32'(c - 4);
            chk("stream_head", out_instr, exp_head);
            acc = in_ready;
            tick();
            if (acc) y++;
            chk("stream_count", 32'(count), 32'd3);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("stream_pushes", 32'(y), 32'd7);
        chk("stream_tail_head", out_instr, 32'h00002024);
        chk("stream_in_ready", 32'(in_ready), 32'd1);

        // branch pushed, then flush with push at count 3
        in_valid = 1'b1; in_instr = 32'h10000003; in_pc = 32'h00000500; out_ready = 1'b1;
        tick();
        chk("br_count", 32'(count), 32'd3);
        chk("br_head", out_instr, 32'h00002025);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h24420001; out_ready = 1'b0;
        tick();
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_instr", out_instr, 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_instr = 32'h00221821; in_pc = 32'h00000600;
        tick();
        chk("postflush_count", 32'(count), 32'd1);
        chk("postflush_instr", out_instr, 32'h00221821);
        chk("postflush_in_ds", 32'(out_in_ds), 32'd0);

        // reserved opcode, store, jr, delay-slot nop via push+pop at count 1
        in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h00000604; out_ready = 1'b1;
        tick();
        chk("ri_instr", out_instr, 32'hFC000000);
        chk("ri_flag", 32'(out_ri), 32'd1);
        chk("ri_count", 32'(count), 32'd1);
        in_instr = 32'hAC220000; in_pc = 32'h00000608;
        tick();
        chk("sw_mem_write", 32'(out_mem_write), 32'd1);
        chk("sw_ri", 32'(out_ri), 32'd0);
        chk("sw_mem_read", 32'(out_mem_read), 32'd0);
        in_instr = 32'h03E00008; in_pc = 32'h0000060C;
        tick();
        chk("jr_is_bj", 32'(out_is_bj), 32'd1);
        chk("jr_in_ds", 32'(out_in_ds), 32'd0);
        in_instr = 32'h00000000; in_pc = 32'h00000610;
        tick();
        chk("nop_in_ds", 32'(out_in_ds), 32'd1);
        chk("nop_is_bj", 32'(out_is_bj), 32'd0);
        chk("nop_pc", out_pc, 32'h00000610);

        // reset overrides a push
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h8C220004; out_ready = 1'b0;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst2_count", 32'(count), 32'd0);
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_pc", out_pc, 32'd0);
        tick();
        chk("rst2_hold", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
